pixel_reorder_buffer: RTL
=========================

PIXEL_REORDER_BUFFER -- requirements
Module: pixel_reorder_buffer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of ray-tracing core input channels, legal range 1..8.
REQ-002 SHALL have parameter DEPTH, default 4: per-core FIFO depth in pixels, power of two, at least 2.
REQ-003 SHALL have parameter DATA_W, default 24: pixel width, packed {r,g,b}.
REQ-004 SHALL have parameter DIM_W, default 12: width of the frame dimension inputs and counters.
REQ-005 SHALL have port aclk, input, 1: sole clock, all state on the rising edge.
REQ-006 SHALL have port aresetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: single-cycle pulse that loads the configuration and begins a frame.
REQ-008 SHALL have port cfg_active_cores, input, 4: number of cores used for this frame.
REQ-009 SHALL have ports cfg_width and cfg_height, input, DIM_W each: frame size in pixels.
REQ-010 SHALL have port in_data, input, NUM_CORES*DATA_W: core i pixel in slice [i*DATA_W +: DATA_W].
REQ-011 SHALL have ports in_valid (input) and in_ready (output), NUM_CORES each: per-core handshake.
REQ-012 SHALL have ports out_data (output, DATA_W), out_valid (output, 1) and out_ready (input, 1): stream to the packer.
REQ-013 SHALL have ports out_user and out_last, output, 1 each: start-of-frame and end-of-line markers.
REQ-014 SHALL have ports busy and frame_done, output, 1 each: frame in progress, and a one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 In IDLE, start SHALL move the FSM to RUN and load the configuration registers.
REQ-017 In RUN, the output transfer of pixel (cfg_width-1, cfg_height-1) SHALL move the FSM to DONE.
REQ-018 DONE SHALL last one cycle, assert frame_done for that cycle, and return to IDLE.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 Configuration SHALL be sampled only on an accepted start; input changes during RUN have no effect.
REQ-021 The effective core count A SHALL be cfg_active_cores clamped to 1..NUM_CORES; 0 maps to 1.
REQ-022 A width or height of 0 SHALL be treated as 1.
REQ-023 Each core SHALL have its own FIFO of DEPTH entries.
REQ-024 in_ready[i] SHALL equal (state==RUN) AND (i < A) AND FIFO i not full.
REQ-025 in_ready[i] SHALL have no combinational path from out_ready.
REQ-026 A push SHALL occur when in_valid[i] and in_ready[i] are both high; all cores may push in the same cycle.
REQ-027 Pixel n of the frame (raster order) SHALL be taken from core (n mod A); read pointer ptr starts at 0 on start.
REQ-028 out_valid SHALL equal (state==RUN) AND FIFO[ptr] not empty; out_data SHALL be the head of FIFO[ptr].
REQ-029 On an output transfer (out_valid and out_ready) FIFO[ptr] SHALL pop and ptr SHALL advance, wrapping from A-1 to 0.
REQ-030 While out_valid is high and out_ready is low, out_data and out_valid SHALL be held stable.
REQ-031 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged; data order is preserved.
REQ-032 A full FIFO SHALL keep in_ready low in a cycle in which it pops (no write bypass).
REQ-033 out_user SHALL be high with out_valid only for pixel (0,0).
REQ-034 out_last SHALL be high with out_valid when col == width-1.
REQ-035 The col counter SHALL wrap to 0 after width-1 and increment row; counters advance only on output transfers.
REQ-036 On entering IDLE from DONE, all FIFOs SHALL be flushed and ptr and the counters cleared.
REQ-037 busy SHALL be high in RUN and DONE.
REQ-038 Output latency SHALL be one cycle: a pixel pushed into an empty FIFO[ptr] at edge k is presented at edge k+1.

Reset
REQ-039 aresetn low SHALL asynchronously force IDLE, empty FIFOs, ptr=0, col=row=0, and the configuration registers to A=1, width=1, height=1.
REQ-040 During reset, every output (in_ready, out_valid, out_user, out_last, busy, frame_done) SHALL read 0 and out_data SHALL read 0.
REQ-041 Reset asserted mid-frame SHALL discard all buffered pixels; after release the block SHALL wait in IDLE for start.

Verification
REQ-042 A=4, width=4, height=2, each core sends its 2 pixels 0x0i0k, out_ready=1 -> 8 pixels in order core0,1,2,3,0,1,2,3; out_user on 1st; out_last on 4th and 8th; frame_done one cycle after the 8th transfer.
REQ-043 Core 3 delivers first while core 0 is delayed 10 cycles -> out_valid stays 0 until core 0 pixel arrives; output order is still correct.
REQ-044 out_ready=0 for 20 cycles, DEPTH=4 -> in_ready of each used core drops after 4 pushes; no data lost; output stable during the stall.
REQ-045 cfg_active_cores=0 and =7 with NUM_CORES=4 -> behaves as A=1 and A=4 respectively; in_ready of unused cores stays 0.
REQ-046 aresetn pulsed low mid-frame -> all outputs 0 immediately; a new start yields a correct complete frame with no stale pixels.

Source files
------------

// File: rtl/pixel_reorder_buffer_if.sv
// Stream/handshake bundle between the ray-tracing cores, the reorder buffer and the packer.
// The reorder buffer uses the slave modport; whoever drives it uses master.
interface pixel_reorder_buffer_if #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 24,
   parameter int DIM_W     = 12
);
   logic                          start;
   logic [3:0]                    cfg_active_cores;
   logic [DIM_W-1:0]              cfg_width;
   logic [DIM_W-1:0]              cfg_height;
   logic [NUM_CORES*DATA_W-1:0]   in_data;
   logic [NUM_CORES-1:0]          in_valid;
   logic [NUM_CORES-1:0]          in_ready;
   logic [DATA_W-1:0]             out_data;
   logic                          out_valid;
   logic                          out_ready;
   logic                          out_user;
   logic                          out_last;
   logic                          busy;
   logic                          frame_done;

   modport master (
      output start, cfg_active_cores, cfg_width, cfg_height, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_user, out_last, busy, frame_done
   );

   modport slave (
      input  start, cfg_active_cores, cfg_width, cfg_height, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_user, out_last, busy, frame_done
   );
endinterface

// File: rtl/pixel_reorder_buffer.sv
// Merges per-core pixel streams into one raster-ordered stream: pixel n comes from core n mod A.
// Each core owns a small FIFO; a round-robin read pointer walks the active cores.
module pixel_reorder_buffer #(
   parameter int NUM_CORES = 4,
   parameter int DEPTH     = 4,
   parameter int DATA_W    = 24,
   parameter int DIM_W     = 12
) (
   input logic                   aclk,
   input logic                   aresetn,
   pixel_reorder_buffer_if.slave bus
);
   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     last_core_q, last_core_d;
   logic [DIM_W-1:0]     width_m1_q, width_m1_d;
   logic [DIM_W-1:0]     height_m1_q, height_m1_d;
   logic [DIM_W-1:0]     col_q, col_d;
   logic [DIM_W-1:0]     row_q, row_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [AW-1:0]        wr_ptr_q [NUM_CORES];
   logic [AW-1:0]        wr_ptr_d [NUM_CORES];
   logic [AW-1:0]        rd_ptr_q [NUM_CORES];
   logic [AW-1:0]        rd_ptr_d [NUM_CORES];
   logic [CW-1:0]        count_q  [NUM_CORES];
   logic [CW-1:0]        count_d  [NUM_CORES];
   logic [DATA_W-1:0]    fifo_mem_q [NUM_CORES][DEPTH];

   logic [PTR_W-1:0]     act_m1;
   logic [NUM_CORES-1:0] in_ready;
   logic [NUM_CORES-1:0] push;
   logic [NUM_CORES-1:0] pop_vec;
   logic                 out_valid;
   logic                 pop;
   logic                 last_pixel;

   // Effective core count minus one: 0 means one core, anything above NUM_CORES saturates.
   always_comb begin
      int act;
      act = int'(bus.cfg_active_cores);
      if (act == 0) begin
         act = 1;
      end else if (act > NUM_CORES) begin
         act = NUM_CORES;
      end
      act_m1 = PTR_W'(act - 1);
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: default every comb output first so no path leaves it unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (pop && last_pixel) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         in_ready[i] = (state_q == RUN) && (PTR_W'(i) <= last_core_q) &&
                       (count_q[i] != CW'(DEPTH));
      end
      out_valid      = (state_q == RUN) && (count_q[ptr_q] != '0);
      bus.out_data   = out_valid ? fifo_mem_q[ptr_q][rd_ptr_q[ptr_q]] : '0;
      bus.out_user   = out_valid && (col_q == '0) && (row_q == '0);
      bus.out_last   = out_valid && (col_q == width_m1_q);
      bus.busy       = (state_q != IDLE);
      bus.frame_done = (state_q == DONE);
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign pop           = out_valid && bus.out_ready;
   assign push          = bus.in_valid & in_ready;
   assign last_pixel    = (col_q == width_m1_q) && (row_q == height_m1_q);

   // ---------------- Datapath next state ----------------
   always_comb begin
      last_core_d = last_core_q;
      width_m1_d  = width_m1_q;
      height_m1_d = height_m1_q;
      ptr_d       = ptr_q;
      col_d       = col_q;
      row_d       = row_q;

      if ((state_q == IDLE) && bus.start) begin
         last_core_d = act_m1;
         width_m1_d  = (bus.cfg_width  == '0) ? '0 : bus.cfg_width  - 1'b1;
         height_m1_d = (bus.cfg_height == '0) ? '0 : bus.cfg_height - 1'b1;
         ptr_d       = '0;
         col_d       = '0;
         row_d       = '0;
      end

      if (pop) begin
         ptr_d = (ptr_q == last_core_q) ? '0 : ptr_q + 1'b1;
         if (col_q == width_m1_q) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      for (int i = 0; i < NUM_CORES; i++) begin
         pop_vec[i]  = pop && (ptr_q == PTR_W'(i));
         wr_ptr_d[i] = push[i]    ? wr_ptr_q[i] + 1'b1 : wr_ptr_q[i];
         rd_ptr_d[i] = pop_vec[i] ? rd_ptr_q[i] + 1'b1 : rd_ptr_q[i];
         unique case ({push[i], pop_vec[i]})
            2'b10:   count_d[i] = count_q[i] + 1'b1;
            2'b01:   count_d[i] = count_q[i] - 1'b1;
            default: count_d[i] = count_q[i];
         endcase
      end

      // Leaving DONE flushes everything so the next frame starts clean.
      if (state_q == DONE) begin
         ptr_d = '0;
         col_d = '0;
         row_d = '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            count_d[i]  = '0;
         end
      end
   end

   // ---------------- State register ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         last_core_q <= '0;
         width_m1_q  <= '0;
         height_m1_q <= '0;
         ptr_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         last_core_q <= last_core_d;
         width_m1_q  <= width_m1_d;
         height_m1_q <= height_m1_d;
         ptr_q       <= ptr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         for (int i = 0; i < NUM_CORES; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
      end
   end

   // NOTE: pixel storage is not reset; the reset counts mark it empty and out_data is gated to 0.
   always_ff @(posedge aclk) begin
      for (int i = 0; i < NUM_CORES; i++) begin
         if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= bus.in_data[i*DATA_W +: DATA_W];
      end
   end
endmodule
